// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - Ethernet II header constants and receive-filter state encoding
package eth_pkg;

    localparam int          ETH_HDR_BYTES     = 14;
    localparam logic [47:0] ETH_BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;
    localparam logic [15:0] ETHERTYPE_IPV4    = 16'h0800;
    localparam logic [15:0] ETHERTYPE_ARP     = 16'h0806;

    typedef enum logic [1:0] {
        ST_HEADER  = 2'd0,
        ST_HDR_OUT = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DROP    = 2'd3
    } eth_state_e;

endpackage

// File: rtl/eth_rx_frame_filter.sv
// rtl/eth_rx_frame_filter.sv - Ethernet II header parser and destination MAC filter
module eth_rx_frame_filter
    import eth_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC        = 48'h02_00_00_00_00_01,
    parameter bit          ACCEPT_BROADCAST = 1'b1,
    parameter bit          PROMISCUOUS      = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic        m_hdr_valid,
    input  logic        m_hdr_ready,
    output logic [47:0] m_hdr_dest_mac,
    output logic [47:0] m_hdr_src_mac,
    output logic [15:0] m_hdr_ethertype,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        frame_dropped,
    output logic        runt_frame
);

    eth_state_e  r_state;
    logic [3:0]  r_cnt;
    logic [7:0]  r_hdr [0:ETH_HDR_BYTES-1];
    logic        r_frame_dropped;
    logic        r_runt_frame;

    logic        w_pass;
    logic        w_hdr_acc;
    logic        w_last_hdr_byte;
    logic        w_match;
    logic [47:0] w_dest;

    assign w_dest = {r_hdr[0], r_hdr[1], r_hdr[2], r_hdr[3], r_hdr[4], r_hdr[5]};

    // Destination bytes are all registered by the time byte 13 arrives.
    assign w_match = PROMISCUOUS
                   | (w_dest == LOCAL_MAC)
                   | (ACCEPT_BROADCAST & (w_dest == ETH_BROADCAST_MAC));

    assign w_hdr_acc       = (r_state == ST_HEADER) & s_axis_tvalid;
    assign w_last_hdr_byte = (r_cnt == 4'(ETH_HDR_BYTES - 1));
    assign w_pass          = (r_state == ST_PAYLOAD);

    always_comb begin
        s_axis_tready = 1'b0;
        case (r_state)
            ST_HEADER,
            ST_DROP:    s_axis_tready = 1'b1;
            ST_PAYLOAD: s_axis_tready = m_axis_tready;
            default:    s_axis_tready = 1'b0;
        endcase
    end

    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tvalid = w_pass & s_axis_tvalid;
    assign m_axis_tlast  = w_pass & s_axis_tlast;
    assign m_axis_tuser  = w_pass & s_axis_tuser;

    assign m_hdr_valid     = (r_state == ST_HDR_OUT);
    assign m_hdr_dest_mac  = w_dest;
    assign m_hdr_src_mac   = {r_hdr[6], r_hdr[7], r_hdr[8], r_hdr[9], r_hdr[10], r_hdr[11]};
    assign m_hdr_ethertype = {r_hdr[12], r_hdr[13]};
    assign frame_dropped   = r_frame_dropped;
    assign runt_frame      = r_runt_frame;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ETH_HDR_BYTES; i++) begin
                r_hdr[i] <= 8'h00;
            end
        end else begin
            // A runt's partial bytes may land here; the next full header overwrites them.
            for (int i = 0; i < ETH_HDR_BYTES; i++) begin
                if (w_hdr_acc && (r_cnt == 4'(i))) begin
                    r_hdr[i] <= s_axis_tdata;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_HEADER;
            r_cnt           <= 4'd0;
            r_frame_dropped <= 1'b0;
            r_runt_frame    <= 1'b0;
        end else begin
            r_frame_dropped <= 1'b0;
            r_runt_frame    <= 1'b0;
            case (r_state)
                ST_HEADER: begin
                    if (s_axis_tvalid) begin
                        if (s_axis_tlast) begin
                            r_runt_frame <= 1'b1;
                            r_cnt        <= 4'd0;
                        end else if (w_last_hdr_byte) begin
                            r_cnt           <= 4'd0;
                            r_state         <= w_match ? ST_HDR_OUT : ST_DROP;
                            r_frame_dropped <= ~w_match;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                ST_HDR_OUT: begin
                    if (m_hdr_ready) begin
                        r_state <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
                        r_state <= ST_HEADER;
                        r_cnt   <= 4'd0;
                    end
                end
                ST_DROP: begin
                    if (s_axis_tvalid && s_axis_tlast) begin
                        r_state <= ST_HEADER;
                        r_cnt   <= 4'd0;
                    end
                end
                default: begin
                    r_state <= ST_HEADER;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_rx_frame_filter.sv
// tb/tb_eth_rx_frame_filter.sv - directed checks of the Ethernet receive frame filter
module tb_eth_rx_frame_filter;
    import eth_pkg::*;

    localparam logic [47:0] MY_MAC    = 48'h02_00_00_00_00_01;
    localparam logic [47:0] OTHER_MAC = 48'h02_00_00_00_00_99;
    localparam logic [47:0] SRC_MAC   = 48'h02_AA_BB_CC_DD_EE;

    typedef struct packed {
        logic [47:0] d;
        logic [47:0] s;
        logic [15:0] t;
    } hdr_t;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic [7:0]  s_tdata;
    logic        s_tvalid, s_tlast, s_tuser, s_tready;
    logic        m_hdr_valid, m_hdr_ready;
    logic [47:0] hdr_dest, hdr_src;
    logic [15:0] hdr_type;
    logic [7:0]  m_tdata;
    logic        m_tvalid, m_tready, m_tlast, m_tuser;
    logic        dropped, runt;

    logic [7:0]  b_s_tdata;
    logic        b_s_tvalid, b_s_tlast, b_s_tuser, b_s_tready;
    logic        b_hdr_valid;
    logic        b_ready_one;
    logic [47:0] b_dest, b_src;
    logic [15:0] b_type;
    logic [7:0]  b_m_tdata;
    logic        b_m_tvalid, b_m_tlast, b_m_tuser;
    logic        b_dropped, b_runt;

    eth_rx_frame_filter dut (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_hdr_valid(m_hdr_valid), .m_hdr_ready(m_hdr_ready),
        .m_hdr_dest_mac(hdr_dest), .m_hdr_src_mac(hdr_src), .m_hdr_ethertype(hdr_type),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .frame_dropped(dropped), .runt_frame(runt)
    );

    eth_rx_frame_filter #(.ACCEPT_BROADCAST(1'b0)) dut_nobc (
        .clk(clk), .reset(reset),
        .s_axis_tdata(b_s_tdata), .s_axis_tvalid(b_s_tvalid), .s_axis_tready(b_s_tready),
        .s_axis_tlast(b_s_tlast), .s_axis_tuser(b_s_tuser),
        .m_hdr_valid(b_hdr_valid), .m_hdr_ready(b_ready_one),
        .m_hdr_dest_mac(b_dest), .m_hdr_src_mac(b_src), .m_hdr_ethertype(b_type),
        .m_axis_tdata(b_m_tdata), .m_axis_tvalid(b_m_tvalid), .m_axis_tready(b_ready_one),
        .m_axis_tlast(b_m_tlast), .m_axis_tuser(b_m_tuser),
        .frame_dropped(b_dropped), .runt_frame(b_runt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    hdr_t       mon_hdr [$];
    logic [9:0] mon_pay [$];
    int         n_drop = 0, n_runt = 0, b_drop = 0, b_beats = 0, b_hdrs = 0;
    int         cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_hdr_valid && m_hdr_ready) mon_hdr.push_back({hdr_dest, hdr_src, hdr_type});
        if (m_tvalid && m_tready) mon_pay.push_back({m_tuser, m_tlast, m_tdata});
        if (dropped) n_drop <= n_drop + 1;
        if (runt) n_runt <= n_runt + 1;
        if (b_dropped) b_drop <= b_drop + 1;
        if (b_m_tvalid) b_beats <= b_beats + 1;
        if (b_hdr_valid) b_hdrs <= b_hdrs + 1;
    end

    bit stall_en = 1'b0;
    initial begin
        m_tready    = 1'b1;
        m_hdr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_en) begin
                m_tready    = ($urandom_range(0, 3) != 0);
                m_hdr_ready = ($urandom_range(0, 2) != 0);
            end else begin
                m_tready    = 1'b1;
                m_hdr_ready = 1'b1;
            end
        end
    end

    logic [7:0] tx_q [$];

    task automatic build_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                               input int plen, input bit rnd);
        tx_q.delete();
        for (int i = 0; i < 6; i++) tx_q.push_back(d[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) tx_q.push_back(s[47-8*i -: 8]);
        tx_q.push_back(t[15:8]);
        tx_q.push_back(t[7:0]);
        for (int i = 0; i < plen; i++) tx_q.push_back(rnd ? 8'($urandom_range(0, 255)) : 8'(i));
    endtask

    // Called and returns at posedge+1; stop_at >= 0 leaves that byte presented, unaccepted.
    task automatic send(input bit gaps, input bit last_user, input int stop_at);
        for (int i = 0; i < tx_q.size(); i++) begin
            if (gaps) begin
                s_tvalid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            s_tvalid = 1'b1;
            s_tdata  = tx_q[i];
            s_tlast  = (i == tx_q.size() - 1);
            s_tuser  = (i == tx_q.size() - 1) && last_user;
            if (i == stop_at) return;
            for (int w = 0; ; w++) begin
                @(negedge clk);
                if (s_tready) break;
                if (w > 500) begin
                    check("accept_timeout", 64'd0, 64'd1);
                    s_tvalid = 1'b0;
                    return;
                end
            end
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        int hb, pb, db, rb, t0, nr, exp_drop, plen, sel;
        bit tu;
        logic [47:0] dmac;
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int hb, pb, db, rb, t0, nr, exp_drop, plen, sel;
        bit tu;
        logic [47:0] dmac;
        reset = 1'b1;
        s_tdata = 8'h00; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
        b_s_tdata = 8'h00; b_s_tvalid = 1'b0; b_s_tlast = 1'b0; b_s_tuser = 1'b0;
        b_ready_one = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_tready", s_tready, 1);
        check("rst_hdr_valid", m_hdr_valid, 0);
        check("rst_dest", hdr_dest, 0);
        check("rst_type", hdr_type, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_pulses", {dropped, runt}, 0);
        reset = 1'b0;
        idle(2);

        // Unicast IPv4 with 46-byte incrementing payload
        hb = mon_hdr.size(); pb = mon_pay.size(); db = n_drop; rb = n_runt;
        build_frame(MY_MAC, SRC_MAC, ETHERTYPE_IPV4, 46, 1'b0);
        send(1'b0, 1'b0, -1);
        idle(2);
        check("t1_hdr_cnt", mon_hdr.size() - hb, 1);
        if (mon_hdr.size() > hb) begin
            check("t1_dest", mon_hdr[hb].d, MY_MAC);
            check("t1_src", mon_hdr[hb].s, SRC_MAC);
            check("t1_type", mon_hdr[hb].t, 16'h0800);
        end
        check("t1_pay_cnt", mon_pay.size() - pb, 46);
        for (int i = 0; i < 46 && pb + i < mon_pay.size(); i++)
            check("t1_pay", mon_pay[pb+i], {1'b0, (i == 45), 8'(i)});
        check("t1_no_pulses", (n_drop - db) + (n_runt - rb), 0);

        // Broadcast ARP: accepted by default instance
        hb = mon_hdr.size(); pb = mon_pay.size();
        build_frame(ETH_BROADCAST_MAC, SRC_MAC, ETHERTYPE_ARP, 28, 1'b0);
        send(1'b0, 1'b0, -1);
        idle(2);
        check("t2_hdr_cnt", mon_hdr.size() - hb, 1);
        if (mon_hdr.size() > hb) check("t2_type", mon_hdr[hb].t, 16'h0806);
        check("t2_pay_cnt", mon_pay.size() - pb, 28);

        // Same frame into the instance with broadcast disabled
        db = b_drop; nr = 0;
        for (int i = 0; i < tx_q.size(); i++) begin
            b_s_tvalid = 1'b1;
            b_s_tdata  = tx_q[i];
            b_s_tlast  = (i == tx_q.size() - 1);
            @(negedge clk);
            if (!b_s_tready) nr++;
            if (i == 14) check("t2b_drop_pulse_timing", b_dropped, 1);
            @(posedge clk);
            #1;
        end
        b_s_tvalid = 1'b0; b_s_tlast = 1'b0;
        idle(2);
        check("t2b_tready_held", nr, 0);
        check("t2b_drop_cnt", b_drop - db, 1);
        check("t2b_no_beats", b_beats, 0);
        check("t2b_no_hdr", b_hdrs, 0);

        // Non-matching unicast, then a good frame back to back
        hb = mon_hdr.size(); pb = mon_pay.size(); db = n_drop;
        build_frame(OTHER_MAC, SRC_MAC, ETHERTYPE_IPV4, 10, 1'b0);
        send(1'b0, 1'b0, -1);
        check("t3_drop_cnt", n_drop - db, 1);
        check("t3_drop_no_hdr", mon_hdr.size() - hb, 0);
        check("t3_drop_no_pay", mon_pay.size() - pb, 0);
        build_frame(MY_MAC, SRC_MAC, ETHERTYPE_IPV4, 5, 1'b0);
        t0 = cyc;
        send(1'b0, 1'b0, -1);
        check("t3_good_cycles", cyc - t0, 20);
        idle(1);
        check("t3_good_hdr", mon_hdr.size() - hb, 1);
        check("t3_good_pay", mon_pay.size() - pb, 5);

        // Runts: 10 bytes, then 14 bytes
        hb = mon_hdr.size(); pb = mon_pay.size(); rb = n_runt;
        build_frame(MY_MAC, SRC_MAC, ETHERTYPE_IPV4, 0, 1'b0);
        repeat (4) void'(tx_q.pop_back());
        send(1'b0, 1'b0, -1);
        build_frame(MY_MAC, SRC_MAC, ETHERTYPE_IPV4, 0, 1'b0);
        send(1'b0, 1'b0, -1);
        idle(2);
        check("t4_runt_cnt", n_runt - rb, 2);
        check("t4_no_hdr", mon_hdr.size() - hb, 0);
        check("t4_no_pay", mon_pay.size() - pb, 0);

        // 100 random frames with source gaps and sink stalls
        stall_en = 1'b1;
        db = n_drop; exp_drop = 0;
        for (int f = 0; f < 100; f++) begin
            sel  = $urandom_range(0, 3);
            dmac = (sel == 3) ? OTHER_MAC : (sel == 2) ? ETH_BROADCAST_MAC : MY_MAC;
            plen = $urandom_range(1, 16);
            tu   = 1'($urandom_range(0, 1));
            hb = mon_hdr.size(); pb = mon_pay.size();
            build_frame(dmac, SRC_MAC, 16'(f), plen, 1'b1);
            send(1'b1, tu, -1);
            if (sel == 3) begin
                exp_drop++;
                check("rnd_drop_no_pay", mon_pay.size() - pb, 0);
            end else begin
                check("rnd_hdr_cnt", mon_hdr.size() - hb, 1);
                if (mon_hdr.size() > hb) check("rnd_type", mon_hdr[hb].t, 16'(f));
                check("rnd_pay_cnt", mon_pay.size() - pb, plen);
                for (int i = 0; i < plen && pb + i < mon_pay.size(); i++)
                    check("rnd_pay", mon_pay[pb+i],
                          {(i == plen - 1) && tu, (i == plen - 1), tx_q[14+i]});
            end
        end
        stall_en = 1'b0;
        idle(2);
        check("rnd_drop_total", n_drop - db, exp_drop);

        // Reset asserted with payload byte 20 presented
        pb = mon_pay.size();
        build_frame(MY_MAC, SRC_MAC, ETHERTYPE_IPV4, 40, 1'b0);
        send(1'b0, 1'b0, 34);
        check("t6_pre_m_tvalid", m_tvalid, 1);
        #1 reset = 1'b1;
        #1;
        check("t6_m_tvalid", m_tvalid, 0);
        check("t6_s_tready", s_tready, 1);
        check("t6_hdr_valid", m_hdr_valid, 0);
        check("t6_dest", hdr_dest, 0);
        check("t6_partial_pay", mon_pay.size() - pb, 20);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0; s_tlast = 1'b0;
        idle(1);
        reset = 1'b0;
        idle(1);
        hb = mon_hdr.size(); pb = mon_pay.size();
        build_frame(MY_MAC, 48'h02_11_22_33_44_55, ETHERTYPE_ARP, 6, 1'b0);
        send(1'b0, 1'b0, -1);
        idle(1);
        check("t6_after_hdr", mon_hdr.size() - hb, 1);
        if (mon_hdr.size() > hb) check("t6_after_src", mon_hdr[hb].s, 48'h02_11_22_33_44_55);
        check("t6_after_pay", mon_pay.size() - pb, 6);
        if (mon_pay.size() > pb) check("t6_after_first", mon_pay[pb], 10'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
